// File: rtl/pe_mem_arbiter.sv
// Round-robin arbiter that shares one memory bus port among NUM_PE processing elements.
// One transaction at a time: IDLE (select) -> BUSY (wait for bus_ack or timeout) -> RESP (pulse ack).
module pe_mem_arbiter #(
    parameter int NUM_PE  = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255,
    localparam int IDW    = (NUM_PE > 1) ? $clog2(NUM_PE) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_PE-1:0]        pe_mem_read,
    input  logic [NUM_PE-1:0]        pe_mem_write,
    input  logic [NUM_PE*ADDR_W-1:0] pe_mem_address,
    input  logic [NUM_PE*DATA_W-1:0] pe_wdata,
    output logic [NUM_PE-1:0]        pe_mem_ack,
    output logic [NUM_PE-1:0]        pe_data_ready,
    output logic [NUM_PE-1:0]        pe_err,
    output logic [DATA_W-1:0]        pe_rdata,
    output logic                     bus_read,
    output logic                     bus_write,
    output logic [ADDR_W-1:0]        bus_address,
    output logic [DATA_W-1:0]        bus_wdata,
    input  logic                     bus_ack,
    input  logic [DATA_W-1:0]        bus_rdata,
    output logic [IDW-1:0]           grant_id,
    output logic                     busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam int               CNT_W    = 16;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [IDW:0]     NUM_PE_X = (IDW+1)'(NUM_PE);
    localparam logic [IDW-1:0]   LAST_ID  = IDW'(NUM_PE - 1);

    state_t              r_state;
    logic [IDW-1:0]      r_rr_ptr;
    logic [IDW-1:0]      r_grant;
    logic                r_is_write;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_bus_read;
    logic                r_bus_write;
    logic [ADDR_W-1:0]   r_bus_address;
    logic [DATA_W-1:0]   r_bus_wdata;
    logic [NUM_PE-1:0]   r_pe_mem_ack;
    logic [NUM_PE-1:0]   r_pe_data_ready;
    logic [NUM_PE-1:0]   r_pe_err;
    logic [DATA_W-1:0]   r_pe_rdata;
    logic                r_busy;

    logic [NUM_PE-1:0]   w_req;
    logic [NUM_PE-1:0]   w_grant_oh;
    logic                w_found;
    logic [IDW-1:0]      w_sel;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;

    generate
        for (genvar gi = 0; gi < NUM_PE; gi++) begin : g_pe
            assign w_req[gi]      = pe_mem_read[gi] | pe_mem_write[gi];
            assign w_grant_oh[gi] = (r_grant == IDW'(gi));
        end
    endgenerate

    // First requester at or after r_rr_ptr, wrapping; the last-served PE ends up searched last.
    always_comb begin : rr_search
        logic [IDW:0] v_idx;
        w_found = 1'b0;
        w_sel   = '0;
        v_idx   = '0;
        for (int k = 0; k < NUM_PE; k++) begin
            v_idx = {1'b0, r_rr_ptr} + (IDW+1)'(k);
            if (v_idx >= NUM_PE_X) begin
                v_idx = v_idx - NUM_PE_X;
            end
            if (!w_found && w_req[v_idx[IDW-1:0]]) begin
                w_found = 1'b1;
                w_sel   = v_idx[IDW-1:0];
            end
        end
    end

    assign w_sel_addr  = pe_mem_address[w_sel*ADDR_W +: ADDR_W];
    assign w_sel_wdata = pe_wdata[w_sel*DATA_W +: DATA_W];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_rr_ptr        <= '0;
            r_grant         <= '0;
            r_is_write      <= 1'b0;
            r_cnt           <= '0;
            r_bus_read      <= 1'b0;
            r_bus_write     <= 1'b0;
            r_bus_address   <= '0;
            r_bus_wdata     <= '0;
            r_pe_mem_ack    <= '0;
            r_pe_data_ready <= '0;
            r_pe_err        <= '0;
            r_pe_rdata      <= '0;
            r_busy          <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        // A PE raising both read and write is served as a write.
                        r_grant       <= w_sel;
                        r_is_write    <= pe_mem_write[w_sel];
                        r_bus_read    <= ~pe_mem_write[w_sel];
                        r_bus_write   <= pe_mem_write[w_sel];
                        r_bus_address <= w_sel_addr;
                        r_bus_wdata   <= w_sel_wdata;
                        r_cnt         <= '0;
                        r_busy        <= 1'b1;
                        r_state       <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (bus_ack) begin
                        r_bus_read   <= 1'b0;
                        r_bus_write  <= 1'b0;
                        r_pe_mem_ack <= w_grant_oh;
                        if (!r_is_write) begin
                            r_pe_data_ready <= w_grant_oh;
                            r_pe_rdata      <= bus_rdata;
                        end
                        r_state <= S_RESP;
                    end else if (r_cnt == CNT_LAST) begin
                        r_bus_read   <= 1'b0;
                        r_bus_write  <= 1'b0;
                        r_pe_mem_ack <= w_grant_oh;
                        r_pe_err     <= w_grant_oh;
                        r_state      <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_pe_mem_ack    <= '0;
                    r_pe_data_ready <= '0;
                    r_pe_err        <= '0;
                    r_rr_ptr        <= (r_grant == LAST_ID) ? '0 : r_grant + 1'b1;
                    r_cnt           <= '0;
                    r_busy          <= 1'b0;
                    r_state         <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign pe_mem_ack    = r_pe_mem_ack;
    assign pe_data_ready = r_pe_data_ready;
    assign pe_err        = r_pe_err;
    assign pe_rdata      = r_pe_rdata;
    assign bus_read      = r_bus_read;
    assign bus_write     = r_bus_write;
    assign bus_address   = r_bus_address;
    assign bus_wdata     = r_bus_wdata;
    assign grant_id      = r_grant;
    assign busy          = r_busy;

endmodule

// File: tb/tb_pe_mem_arbiter.sv
// Testbench for pe_mem_arbiter: directed scenarios plus randomized traffic against
// a request-table model (pending set, round-robin pointer, last read value).
module tb_pe_mem_arbiter;

    localparam int NP = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NP-1:0]     pe_mem_read = '0;
    logic [NP-1:0]     pe_mem_write = '0;
    logic [NP*AW-1:0]  pe_mem_address = '0;
    logic [NP*DW-1:0]  pe_wdata = '0;
    logic [NP-1:0]     pe_mem_ack;
    logic [NP-1:0]     pe_data_ready;
    logic [NP-1:0]     pe_err;
    logic [DW-1:0]     pe_rdata;
    logic              bus_read;
    logic              bus_write;
    logic [AW-1:0]     bus_address;
    logic [DW-1:0]     bus_wdata;
    logic              bus_ack = 1'b0;
    logic [DW-1:0]     bus_rdata = '0;
    logic [1:0]        grant_id;
    logic              busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model state
    int          rr_m;
    logic [DW-1:0] exp_rdata;

    typedef struct {
        bit            started;
        bit            rd;
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [1:0]    gid;
        bit            held;
        bit            early;
        int            busy_cycles;
        logic [NP-1:0] ack;
        logic [NP-1:0] dr;
        logic [NP-1:0] err;
        logic [DW-1:0] rdata;
        bit            busy_resp;
        int            ack_cyc;
    } obs_t;

    pe_mem_arbiter #(.NUM_PE(NP), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .pe_mem_read(pe_mem_read), .pe_mem_write(pe_mem_write),
        .pe_mem_address(pe_mem_address), .pe_wdata(pe_wdata),
        .pe_mem_ack(pe_mem_ack), .pe_data_ready(pe_data_ready), .pe_err(pe_err),
        .pe_rdata(pe_rdata),
        .bus_read(bus_read), .bus_write(bus_write), .bus_address(bus_address),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    // Bus-side driver. Called at a negedge with the arbiter in IDLE; lat = BUSY cycle index
    // in which bus_ack is driven (>= TO means never). Returns at the next IDLE negedge.
    task automatic txn(input int lat, input logic [DW-1:0] rd_val, input bit drop,
                       input bit stray, output obs_t o);
        @(negedge clk);
        o.started = bus_read | bus_write;
        o.rd = bus_read; o.wr = bus_write; o.addr = bus_address; o.wdata = bus_wdata;
        o.gid = grant_id; o.held = 1'b1; o.early = 1'b0; o.busy_cycles = 0;
        o.ack = '0; o.dr = '0; o.err = '0; o.rdata = pe_rdata; o.busy_resp = 1'b0; o.ack_cyc = 0;
        if (!o.started) begin
            bus_ack = 1'b0;
            return;
        end
        for (int c = 0; c < TO; c++) begin
            if (c > 0) @(negedge clk);
            if (bus_read !== o.rd || bus_write !== o.wr || bus_address !== o.addr ||
                bus_wdata !== o.wdata || busy !== 1'b1 || grant_id !== o.gid) o.held = 1'b0;
            if (pe_mem_ack !== '0) o.early = 1'b1;
            if (bus_read | bus_write) o.busy_cycles++;
            bus_ack   = (c == lat);
            bus_rdata = (c == lat) ? rd_val : $urandom;
            pe_mem_address[o.gid*AW +: AW] = $urandom;
            if (c == lat) break;
        end
        @(negedge clk);
        bus_ack   = stray;
        bus_rdata = $urandom;
        o.ack = pe_mem_ack; o.dr = pe_data_ready; o.err = pe_err; o.rdata = pe_rdata;
        o.busy_resp = busy; o.ack_cyc = cyc;
        if (drop) begin
            pe_mem_read  = pe_mem_read & ~pe_mem_ack;
            pe_mem_write = pe_mem_write & ~pe_mem_ack;
        end
        @(negedge clk);
        bus_ack = 1'b0;
    endtask

    task automatic test_reset();
        obs_t o;
        logic [112:0] outs;
        logic [DW-1:0] v;
        bit seen;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        outs = {pe_mem_ack, pe_data_ready, pe_err, pe_rdata, bus_read, bus_write,
                bus_address, bus_wdata, grant_id, busy};
        checks++;
        if (outs !== '0) begin errors++; $display("FAIL reset_outputs got %h exp 0", outs); end
        reset = 1'b0;
        rr_m = 0; exp_rdata = '0;
        // Complete one read by PE2 so the pointer moves away from 0
        pe_mem_read = 4'b0100;
        pe_mem_address[2*AW +: AW] = 32'h0000_0100;
        txn(0, 32'hA5A5_0001, 1'b1, 1'b0, o);
        checks++;
        if (o.gid !== 2'd2) begin errors++; $display("FAIL reset_pre_grant got %0d exp 2", o.gid); end
        // Abandon a BUSY read to 0x100
        pe_mem_read = 4'b0100;
        pe_mem_address[2*AW +: AW] = 32'h0000_0100;
        @(negedge clk);
        checks++;
        if (!(bus_read === 1'b1 && bus_address === 32'h100)) begin
            errors++; $display("FAIL reset_busy_setup got rd=%b addr=%h exp rd=1 addr=100", bus_read, bus_address);
        end
        #2 reset = 1'b1;
        #1;
        outs = {pe_mem_ack, pe_data_ready, pe_err, pe_rdata, bus_read, bus_write,
                bus_address, bus_wdata, grant_id, busy};
        checks++;
        if (outs !== '0) begin errors++; $display("FAIL reset_async got %h exp 0", outs); end
        @(negedge clk);
        reset = 1'b0;
        pe_mem_read = '0;
        rr_m = 0; exp_rdata = '0;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (pe_mem_ack !== '0 || busy !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin errors++; $display("FAIL reset_no_ack got activity=1 exp 0"); end
        pe_mem_read = 4'hF;
        for (int i = 0; i < NP; i++) pe_mem_address[i*AW +: AW] = $urandom;
        v = $urandom;
        txn(1, v, 1'b1, 1'b0, o);
        pe_mem_read = '0;
        checks++;
        if (o.gid !== 2'd0) begin errors++; $display("FAIL reset_rr_from0 got %0d exp 0", o.gid); end
        checks++;
        if (o.rdata !== v) begin errors++; $display("FAIL reset_post_rdata got %h exp %h", o.rdata, v); end
        rr_m = 1; exp_rdata = v;
        $display("txn reset: grant=%0d ack=%b", o.gid, o.ack);
    endtask

    task automatic test_single_read();
        obs_t o;
        pe_mem_read = 4'b0100;
        pe_mem_address[2*AW +: AW] = 32'h0000_0040;
        txn(2, 32'hDEADBEEF, 1'b1, 1'b0, o);
        checks++;
        if (o.gid !== 2'd2 || o.rd !== 1'b1 || o.wr !== 1'b0 || o.addr !== 32'h40) begin
            errors++; $display("FAIL single_read_req got gid=%0d rd=%b wr=%b addr=%h exp 2 1 0 40", o.gid, o.rd, o.wr, o.addr);
        end
        checks++;
        if (o.ack !== 4'b0100 || o.dr !== 4'b0100 || o.err !== 4'b0000) begin
            errors++; $display("FAIL single_read_resp got ack=%b dr=%b err=%b exp 0100 0100 0000", o.ack, o.dr, o.err);
        end
        checks++;
        if (o.rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL single_read_rdata got %h exp deadbeef", o.rdata); end
        checks++;
        if (o.busy_cycles != 3 || !o.held || o.early) begin
            errors++; $display("FAIL single_read_busy got cycles=%0d held=%b early=%b exp 3 1 0", o.busy_cycles, o.held, o.early);
        end
        checks++;
        if (pe_mem_ack !== '0 || pe_data_ready !== '0) begin
            errors++; $display("FAIL single_read_pulse got ack=%b dr=%b exp 0 0", pe_mem_ack, pe_data_ready);
        end
        rr_m = 3; exp_rdata = 32'hDEADBEEF;
        $display("txn single_read: grant=%0d rdata=%h", o.gid, o.rdata);
    endtask

    task automatic test_timeout();
        obs_t o;
        pe_mem_read = 4'b1000;
        pe_mem_address[3*AW +: AW] = $urandom;
        txn(TO, 32'h0BAD_0BAD, 1'b1, 1'b0, o);
        checks++;
        if (o.gid !== 2'd3 || o.busy_cycles != TO) begin
            errors++; $display("FAIL timeout_len got gid=%0d cycles=%0d exp 3 %0d", o.gid, o.busy_cycles, TO);
        end
        checks++;
        if (o.ack !== 4'b1000 || o.err !== 4'b1000 || o.dr !== 4'b0000) begin
            errors++; $display("FAIL timeout_resp got ack=%b err=%b dr=%b exp 1000 1000 0000", o.ack, o.err, o.dr);
        end
        checks++;
        if (o.rdata !== exp_rdata) begin errors++; $display("FAIL timeout_rdata got %h exp %h", o.rdata, exp_rdata); end
        rr_m = 0;
        $display("txn timeout: grant=%0d err=%b", o.gid, o.err);
    endtask

    task automatic test_round_robin();
        obs_t o;
        int prev;
        logic [DW-1:0] wd [NP];
        pe_mem_write = 4'hF;
        for (int i = 0; i < NP; i++) begin
            wd[i] = $urandom;
            pe_wdata[i*DW +: DW] = wd[i];
        end
        prev = 0;
        for (int n = 0; n < 5; n++) begin
            txn(0, $urandom, 1'b0, 1'b0, o);
            checks++;
            if (o.gid !== 2'(n % NP) || o.wr !== 1'b1 || o.wdata !== wd[n % NP] || o.ack !== 4'(1 << (n % NP))) begin
                errors++; $display("FAIL rr_grant n=%0d got gid=%0d wr=%b wdata=%h ack=%b exp gid=%0d wdata=%h", n, o.gid, o.wr, o.wdata, o.ack, n % NP, wd[n % NP]);
            end
            if (n > 0) begin
                checks++;
                if (o.ack_cyc - prev != 3) begin
                    errors++; $display("FAIL rr_spacing n=%0d got %0d exp 3", n, o.ack_cyc - prev);
                end
            end
            prev = o.ack_cyc;
            $display("txn rr: grant=%0d ack_cycle=%0d", o.gid, o.ack_cyc);
        end
        pe_mem_write = '0;
        rr_m = 1;
    endtask

    task automatic test_read_write_both();
        obs_t o;
        pe_mem_read = 4'b0010; pe_mem_write = 4'b0010;
        pe_wdata[1*DW +: DW] = 32'h0000_1234;
        txn(1, 32'hFFFF_0000, 1'b1, 1'b0, o);
        checks++;
        if (o.gid !== 2'd1 || o.wr !== 1'b1 || o.rd !== 1'b0 || o.wdata !== 32'h1234) begin
            errors++; $display("FAIL rw_both_req got gid=%0d rd=%b wr=%b wdata=%h exp 1 0 1 1234", o.gid, o.rd, o.wr, o.wdata);
        end
        checks++;
        if (o.ack !== 4'b0010 || o.dr !== 4'b0000 || o.rdata !== exp_rdata) begin
            errors++; $display("FAIL rw_both_resp got ack=%b dr=%b rdata=%h exp 0010 0000 %h", o.ack, o.dr, o.rdata, exp_rdata);
        end
        rr_m = 2;
        $display("txn rw_both: grant=%0d wr=%b", o.gid, o.wr);
    endtask

    task automatic test_final_cycle_ack();
        obs_t o;
        logic [DW-1:0] v;
        v = $urandom;
        pe_mem_read = 4'b0001;
        pe_mem_address[0 +: AW] = $urandom;
        txn(TO - 1, v, 1'b1, 1'b0, o);
        checks++;
        if (o.busy_cycles != TO || o.ack !== 4'b0001 || o.err !== 4'b0000 || o.dr !== 4'b0001) begin
            errors++; $display("FAIL final_cycle_ack got cycles=%0d ack=%b err=%b dr=%b exp %0d 0001 0000 0001", o.busy_cycles, o.ack, o.err, o.dr, TO);
        end
        checks++;
        if (o.rdata !== v) begin errors++; $display("FAIL final_cycle_rdata got %h exp %h", o.rdata, v); end
        rr_m = 1; exp_rdata = v;
        $display("txn final_cycle: grant=%0d rdata=%h", o.gid, o.rdata);
    endtask

    task automatic test_random();
        obs_t o;
        bit            pend [NP];
        bit            pw   [NP];
        logic [AW-1:0] pa   [NP];
        logic [DW-1:0] pd   [NP];
        int g, lat, r, kind, exp_cycles;
        bit exp_err;
        logic [DW-1:0] v;
        logic [NP-1:0] oh;
        for (int i = 0; i < NP; i++) pend[i] = 1'b0;
        for (int t = 0; t < 60; t++) begin
            for (int i = 0; i < NP; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    kind = $urandom_range(0, 2);
                    pend[i] = 1'b1;
                    pw[i] = (kind != 0);
                    pa[i] = $urandom;
                    pd[i] = $urandom;
                    pe_mem_read[i]  = (kind != 1);
                    pe_mem_write[i] = (kind != 0);
                    pe_mem_address[i*AW +: AW] = pa[i];
                    pe_wdata[i*DW +: DW] = pd[i];
                end
            end
            g = -1;
            for (int k = 0; k < NP; k++) begin
                if (g < 0 && pend[(rr_m + k) % NP]) g = (rr_m + k) % NP;
            end
            r = $urandom_range(0, 9);
            lat = (r == 9) ? TO : (r == 8) ? TO - 1 : r % 4;
            v = $urandom;
            bus_ack = ($urandom_range(0, 3) == 0);
            txn(lat, v, 1'b1, ($urandom_range(0, 3) == 0), o);
            if (g < 0) begin
                checks++;
                if (o.started) begin errors++; $display("FAIL rand_idle t=%0d got started=1 exp 0", t); end
                $display("txn rand t=%0d: no request", t);
                continue;
            end
            exp_err = (lat >= TO);
            exp_cycles = exp_err ? TO : lat + 1;
            oh = 4'(1 << g);
            checks++;
            if (!o.started || o.gid !== 2'(g)) begin
                errors++; $display("FAIL rand_grant t=%0d got started=%b gid=%0d exp %0d", t, o.started, o.gid, g);
            end
            checks++;
            if (o.wr !== pw[g] || o.rd !== !pw[g] || o.addr !== pa[g] || o.wdata !== pd[g]) begin
                errors++; $display("FAIL rand_bus t=%0d got rd=%b wr=%b addr=%h wdata=%h exp wr=%b addr=%h wdata=%h", t, o.rd, o.wr, o.addr, o.wdata, pw[g], pa[g], pd[g]);
            end
            checks++;
            if (!o.held || o.early || o.busy_cycles != exp_cycles) begin
                errors++; $display("FAIL rand_busy t=%0d got held=%b early=%b cycles=%0d exp 1 0 %0d", t, o.held, o.early, o.busy_cycles, exp_cycles);
            end
            if (!pw[g] && !exp_err) exp_rdata = v;
            checks++;
            if (o.ack !== oh || o.err !== (exp_err ? oh : 4'b0) || o.dr !== ((!pw[g] && !exp_err) ? oh : 4'b0) || o.busy_resp !== 1'b1) begin
                errors++; $display("FAIL rand_resp t=%0d got ack=%b err=%b dr=%b busy=%b exp ack=%b err=%0d", t, o.ack, o.err, o.dr, o.busy_resp, oh, exp_err);
            end
            checks++;
            if (o.rdata !== exp_rdata) begin errors++; $display("FAIL rand_rdata t=%0d got %h exp %h", t, o.rdata, exp_rdata); end
            pend[g] = 1'b0;
            rr_m = (g + 1) % NP;
            $display("txn rand t=%0d: pe=%0d %s lat=%0d err=%0d", t, g, pw[g] ? "wr" : "rd", lat, exp_err);
        end
        pe_mem_read = '0; pe_mem_write = '0;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_timeout();
        test_round_robin();
        test_read_write_both();
        test_final_cycle_ack();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
